// File: rtl/corescore_pkg.sv
// Shared stream constants: AXI-Stream beat width and the IDLE/BUSY state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package corescore_pkg;

  localparam int AXIS_DW = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY
  } rr_state_e;

  // Width of an index field over n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_collector_rr_pick.sv
// Rotate-priority-rotate picker: first requester at or after ptr_i, wrapping modulo NUM_SRC.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_pick
  import corescore_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = id_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               any_o
);

  logic [2*NUM_SRC-1:0] req_dbl;
  logic [NUM_SRC-1:0]   req_rot;
  int                   off;
  int                   idx;

  // Rotate so ptr_i lands at bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = req_dbl[ptr_i +: NUM_SRC];
    off     = 0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (req_rot[j]) off = j;
    end
    idx = int'(ptr_i) + off;
    if (idx >= NUM_SRC) idx = idx - NUM_SRC;
    gnt_idx_o = ID_W'(idx);
    any_o     = |req_i;
  end

endmodule

// File: rtl/axis_rr_collector.sv
// Packet-atomic round-robin merge of NUM_SRC 8-bit AXI-Stream sources into one stream.
// Latency: beat leaves 1 cycle after acceptance; one idle arbitration cycle between packets.
// Backpressure: only the granted source sees ready, = ~o_tvalid | i_tready. Optional packet
// counter port o_pkt_cnt exists when AXIS_RR_COLLECTOR_PKTCNT_EN is defined.
module axis_rr_collector
  import corescore_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [AXIS_DW*NUM_SRC-1:0] i_tdata,
  input  logic [NUM_SRC-1:0]         i_tlast,
  input  logic [NUM_SRC-1:0]         i_tvalid,
  output logic [NUM_SRC-1:0]         o_tready,
  output logic [AXIS_DW-1:0]         o_tdata,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       i_tready,
  output logic                       o_busy
`ifdef AXIS_RR_COLLECTOR_PKTCNT_EN
  ,
  output logic [15:0]                o_pkt_cnt
`endif
);

  localparam int ID_W = id_width(NUM_SRC);

  rr_state_e          state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               tvalid_q, tvalid_d;
  logic [AXIS_DW-1:0] tdata_q, tdata_d;
  logic               tlast_q, tlast_d;

  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               slot_rdy;
  logic               src_vld;
  logic               src_last;
  logic [AXIS_DW-1:0] src_dat;
  logic               accept;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i     (i_tvalid),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Mux the granted source and drive ready back to it alone.
  always_comb begin
    slot_rdy = (state_q == BUSY) && (!tvalid_q || i_tready);
    src_vld  = 1'b0;
    src_last = 1'b0;
    src_dat  = '0;
    o_tready = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_q == ID_W'(k)) begin
        src_vld     = i_tvalid[k];
        src_last    = i_tlast[k];
        src_dat     = i_tdata[k*AXIS_DW +: AXIS_DW];
        o_tready[k] = slot_rdy;
      end
    end
    accept = slot_rdy && src_vld;
  end

  // Arbitration FSM next state plus output-register load/drain.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && src_last) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_SRC - 1)) ? '0 : grant_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      tvalid_d = 1'b1;
      tdata_d  = src_dat;
      tlast_d  = src_last;
    end else if (i_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any partial packet and held beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  end

  assign o_tvalid = tvalid_q;
  assign o_tdata  = tdata_q;
  assign o_tlast  = tlast_q;
  assign o_busy   = (state_q == BUSY);

`ifdef AXIS_RR_COLLECTOR_PKTCNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  // Count completed packets (accepted tlast beats), wrapping at 16 bits.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (accept && src_last) pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  // Packet counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) pkt_cnt_q <= '0;
    else       pkt_cnt_q <= pkt_cnt_d;
  end

  assign o_pkt_cnt = pkt_cnt_q;
`endif

endmodule
